nn_param_loader: RTL
====================

NN_PARAM_LOADER -- requirements
Module: nn_param_loader

Interface
REQ-001 The block SHALL have these ports, one per line as name, direction, width, meaning:
- clk  input  1  single system clock; all state changes on its rising edge.
- rst  input  1  asynchronous, active-high reset.
- s_valid  input  1  upstream word valid.
- s_data  input  5  upstream parameter word, two's complement.
- s_ready  output  1  loader can accept a word this cycle.
- x0, x1, x2, x3  output  5 each  input features to the network stage.
- w04, w14, w24, w34  output  5 each  hidden neuron 4 weights.
- w05, w15, w25, w35  output  5 each  hidden neuron 5 weights.
- w06, w16, w26, w36  output  5 each  hidden neuron 6 weights.
- w07, w17, w27, w37  output  5 each  hidden neuron 7 weights.
- w48, w58, w68, w78  output  5 each  output neuron 8 weights.
- w49, w59, w69, w79  output  5 each  output neuron 9 weights.
- in_ready  output  1  parameter set valid for the network stage.
- out0_ready, out1_ready  input  1 each  result-valid flags from the network stage.
- frame_cnt  output  8  count of completed frames.
- timeout  output  1  sticky watchdog error flag.

Function
REQ-002 A frame SHALL be 28 words, accepted on rising edges where s_valid and s_ready are both 1.
REQ-003 Word index order SHALL be:
- 0-3: x0-x3.
- 4-7: w04, w14, w24, w34.
- 8-11: w05-w35.
- 12-15: w06-w36.
- 16-19: w07-w37.
- 20-23: w48, w58, w68, w78.
- 24-27: w49, w59, w69, w79.
REQ-004 Accepted words SHALL be written to a staging register bank at the current index, a 5-bit counter running 0..27, and SHALL NOT alter any output port during loading.
REQ-005 Cycles with s_valid=0 SHALL leave the index and staging bank unchanged; s_data SHALL be ignored when no word is accepted.
REQ-006 The state machine SHALL have exactly two states: LOAD (s_ready=1, in_ready=0) and ARMED (s_ready=0, in_ready=1).
REQ-007 On acceptance of index 27, on the same edge:
- all 28 staging values SHALL be copied to the output ports;
- the index SHALL clear to 0;
- the state SHALL become ARMED, so in_ready=1 and s_ready=0 in the next cycle.
REQ-008 Outputs x*/w* SHALL remain constant from that copy until the next completed copy.
REQ-009 In ARMED, a 6-bit watchdog counter wd SHALL be 0 in the first ARMED cycle and increment by 1 every ARMED cycle.
REQ-010 In ARMED, sticky bits seen0 and seen1 SHALL be set by out0_ready and out1_ready, sampled only when wd is at least 1; they SHALL clear on entry to ARMED.
REQ-011 out0_ready and out1_ready SHALL be ignored in LOAD and in the wd=0 cycle.
REQ-012 When the sampled flags plus the seen bits cover both outputs, including both rising in the same cycle, on that edge:
- the state SHALL return to LOAD;
- frame_cnt SHALL increment by 1, wrapping 255 to 0.
REQ-013 If wd=63 and completion per REQ-012 does not occur on that edge:
- the state SHALL return to LOAD;
- timeout SHALL set to 1;
- frame_cnt SHALL be unchanged.
REQ-014 If completion and wd=63 coincide, completion SHALL take priority and timeout SHALL be unchanged.
REQ-015 timeout SHALL clear only on reset.
REQ-016 ARMED SHALL therefore last between 2 and 64 cycles.

Reset
REQ-017 While rst=1, the following SHALL be forced to 0 asynchronously: all x*/w* outputs, the staging bank, the index, wd, seen0, seen1, frame_cnt, timeout and in_ready.
REQ-018 While rst=1, the state SHALL be LOAD.
REQ-019 s_ready SHALL be 0 while rst=1 and 1 from the first cycle after deassertion.
REQ-020 Reset mid-frame SHALL discard the partial frame; reset in ARMED SHALL drop in_ready immediately.

Verification
REQ-021 Load 28 back-to-back words: x0=00100, x1=00010, x2=00100, x3=00001, w04=00011, and so on up to w79=00110. Required: in_ready=1 and s_ready=0 the cycle after word 28; x0=00100, w24=01101, w58=11111, w79=00110.
REQ-022 Same frame with s_valid toggling every cycle. Required: identical outputs, in_ready rising one cycle after the 28th accepted word (cycle 56), and outputs unchanged at all earlier cycles.
REQ-023 ARMED with out0_ready at wd=3 and out1_ready at wd=7. Required: next cycle in_ready=0, s_ready=1, frame_cnt=1, timeout=0.
REQ-024 ARMED with both ready flags held 0. Required: return to LOAD after 64 ARMED cycles, timeout=1, frame_cnt=0; a following good frame gives frame_cnt=1 with timeout still 1.
REQ-025 rst pulse after 10 accepted words. Required: all outputs read 0 during reset; a fresh 28-word frame then loads with correct index alignment (x0 is the first post-reset word).
REQ-026 Run 256 completed frames. Required: frame_cnt reads 255 after the 255th and 0 after the 256th.

Source files
------------

// File: rtl/nn_param_loader.sv
// Streams a 28-word parameter frame into a staging bank, then publishes it to the
// network stage and waits (with a 64-cycle watchdog) for both result flags.
module nn_param_loader (
    input  logic       clk,
    input  logic       rst,
    input  logic       s_valid,
    input  logic [4:0] s_data,
    output logic       s_ready,
    output logic [4:0] x0,
    output logic [4:0] x1,
    output logic [4:0] x2,
    output logic [4:0] x3,
    output logic [4:0] w04,
    output logic [4:0] w14,
    output logic [4:0] w24,
    output logic [4:0] w34,
    output logic [4:0] w05,
    output logic [4:0] w15,
    output logic [4:0] w25,
    output logic [4:0] w35,
    output logic [4:0] w06,
    output logic [4:0] w16,
    output logic [4:0] w26,
    output logic [4:0] w36,
    output logic [4:0] w07,
    output logic [4:0] w17,
    output logic [4:0] w27,
    output logic [4:0] w37,
    output logic [4:0] w48,
    output logic [4:0] w58,
    output logic [4:0] w68,
    output logic [4:0] w78,
    output logic [4:0] w49,
    output logic [4:0] w59,
    output logic [4:0] w69,
    output logic [4:0] w79,
    output logic       in_ready,
    input  logic       out0_ready,
    input  logic       out1_ready,
    output logic [7:0] frame_cnt,
    output logic       timeout
);
    localparam int N_WORDS = 28;

    typedef enum logic {LOAD = 1'b0, ARMED = 1'b1} state_t;

    state_t     state_q, state_d;
    logic [4:0] idx_q, idx_d;
    logic [4:0] stage_q [N_WORDS];
    logic [4:0] stage_d [N_WORDS];
    logic [4:0] par_q   [N_WORDS];
    logic [4:0] par_d   [N_WORDS];
    logic [5:0] wd_q, wd_d;
    logic       seen0_q, seen0_d;
    logic       seen1_q, seen1_d;
    logic [7:0] frame_cnt_q, frame_cnt_d;
    logic       timeout_q, timeout_d;
    logic       in_ready_q, in_ready_d;

    logic       accept;
    logic       last_word;
    logic       hit0, hit1, done;
    logic [N_WORDS-1:0] wr_en;

    assign accept    = (state_q == LOAD) && s_valid;
    assign last_word = accept && (idx_q == 5'(N_WORDS - 1));

    generate
        for (genvar gi = 0; gi < N_WORDS; gi++) begin : g_wr
            assign wr_en[gi] = accept && (idx_q == 5'(gi));
        end
    endgenerate

    // Flags are only meaningful once the network stage has had a cycle to react.
    assign hit0 = out0_ready && (wd_q != 6'd0);
    assign hit1 = out1_ready && (wd_q != 6'd0);
    assign done = (seen0_q || hit0) && (seen1_q || hit1);

    always_comb begin
        state_d     = state_q;
        idx_d       = idx_q;
        wd_d        = wd_q;
        seen0_d     = seen0_q;
        seen1_d     = seen1_q;
        frame_cnt_d = frame_cnt_q;
        timeout_d   = timeout_q;
        in_ready_d  = in_ready_q;
        for (int i = 0; i < N_WORDS; i++) begin
            stage_d[i] = wr_en[i] ? s_data : stage_q[i];
            par_d[i]   = par_q[i];
        end

        case (state_q)
            LOAD: begin
                if (last_word) begin
                    for (int i = 0; i < N_WORDS; i++) begin
                        par_d[i] = stage_d[i];
                    end
                    idx_d      = 5'd0;
                    state_d    = ARMED;
                    in_ready_d = 1'b1;
                    wd_d       = 6'd0;
                    seen0_d    = 1'b0;
                    seen1_d    = 1'b0;
                end else if (accept) begin
                    idx_d = idx_q + 5'd1;
                end
            end
            ARMED: begin
                if (done) begin
                    state_d     = LOAD;
                    in_ready_d  = 1'b0;
                    frame_cnt_d = frame_cnt_q + 8'd1;
                end else if (wd_q == 6'd63) begin
                    state_d    = LOAD;
                    in_ready_d = 1'b0;
                    timeout_d  = 1'b1;
                end else begin
                    wd_d    = wd_q + 6'd1;
                    seen0_d = seen0_q || hit0;
                    seen1_d = seen1_q || hit1;
                end
            end
            default: begin
                state_d    = LOAD;
                in_ready_d = 1'b0;
            end
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q     <= LOAD;
            idx_q       <= 5'd0;
            wd_q        <= 6'd0;
            seen0_q     <= 1'b0;
            seen1_q     <= 1'b0;
            frame_cnt_q <= 8'd0;
            timeout_q   <= 1'b0;
            in_ready_q  <= 1'b0;
            for (int i = 0; i < N_WORDS; i++) begin
                stage_q[i] <= 5'd0;
                par_q[i]   <= 5'd0;
            end
        end else begin
            state_q     <= state_d;
            idx_q       <= idx_d;
            wd_q        <= wd_d;
            seen0_q     <= seen0_d;
            seen1_q     <= seen1_d;
            frame_cnt_q <= frame_cnt_d;
            timeout_q   <= timeout_d;
            in_ready_q  <= in_ready_d;
            for (int i = 0; i < N_WORDS; i++) begin
                stage_q[i] <= stage_d[i];
                par_q[i]   <= par_d[i];
            end
        end
    end

    // Gated by rst so the upstream sees "not ready" for the whole reset window.
    assign s_ready   = (state_q == LOAD) && !rst;
    assign in_ready  = in_ready_q;
    assign frame_cnt = frame_cnt_q;
    assign timeout   = timeout_q;

    assign x0  = par_q[0];
    assign x1  = par_q[1];
    assign x2  = par_q[2];
    assign x3  = par_q[3];
    assign w04 = par_q[4];
    assign w14 = par_q[5];
    assign w24 = par_q[6];
    assign w34 = par_q[7];
    assign w05 = par_q[8];
    assign w15 = par_q[9];
    assign w25 = par_q[10];
    assign w35 = par_q[11];
    assign w06 = par_q[12];
    assign w16 = par_q[13];
    assign w26 = par_q[14];
    assign w36 = par_q[15];
    assign w07 = par_q[16];
    assign w17 = par_q[17];
    assign w27 = par_q[18];
    assign w37 = par_q[19];
    assign w48 = par_q[20];
    assign w58 = par_q[21];
    assign w68 = par_q[22];
    assign w78 = par_q[23];
    assign w49 = par_q[24];
    assign w59 = par_q[25];
    assign w69 = par_q[26];
    assign w79 = par_q[27];
endmodule
